cpu_state_units: RTL and testbench
==================================

Name: cpu_state_units

Overview:
- Holds all architectural state of the single-cycle MIPS-style datapath: program counter, 32x32 register file, and word-addressed data memory.
- All three share one clock and one synchronous reset.
- Control, ALU, instruction ROM and the muxes live outside this block and drive its inputs combinationally.

Parameters:
- PC_W, 5, program counter width in bits (instruction index).
- DATA_W, 32, width of register and memory words.
- RF_AW, 5, register-file address width (2**RF_AW registers).
- DM_AW, 5, data-memory index width (2**DM_AW words).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  PC_W  next PC value.
- pc_out  output  PC_W  current PC.
- rf_ar1  input  RF_AW  read address, port 1.
- rf_ar2  input  RF_AW  read address, port 2.
- rf_aw  input  RF_AW  write address.
- rf_dw  input  DATA_W  write data.
- rf_we  input  1  register write enable.
- rf_dr1  output  DATA_W  read data, port 1.
- rf_dr2  output  DATA_W  read data, port 2.
- dm_addr  input  DATA_W  data-memory address (word index in low DM_AW bits).
- dm_wdata  input  DATA_W  memory write data.
- dm_we  input  1  memory write enable.
- dm_re  input  1  memory read enable.
- dm_rdata  output  DATA_W  memory read data.

Behaviour:
- Reset: checked on rising clk edge; rst=1 has priority over every write.
  - pc_out <= 0.
  - All registers <= 0.
  - All memory words <= 0.
- PC:
  - pc_out <= pc_in on every rising edge when rst=0; no enable, no stall.
  - Arithmetic is PC_W bits, so 31 -> 0 wrap is left to the driver.
- Register file reads:
  - Two asynchronous combinational read ports.
  - rf_dr1 = reg[rf_ar1] and rf_dr2 = reg[rf_ar2], valid in the same cycle the address changes.
- Register file writes:
  - Synchronous: on rising edge with rf_we=1 and rst=0, reg[rf_aw] <= rf_dw.
  - Register 0 is hardwired to zero: writes to address 0 are discarded and reads of 0 always return 0.
- Register read/write collision:
  - Same address read and written in one cycle: read returns the OLD value until the edge, then the new one. No write-to-read bypass.
- Data memory:
  - Index = dm_addr[DM_AW-1:0]; upper bits ignored (aliasing, no fault).
  - Read is asynchronous: dm_rdata = mem[index] when dm_re=1, else 0.
  - Write is synchronous: on rising edge with dm_we=1 and rst=0, mem[index] <= dm_wdata.
  - dm_re and dm_we both high is legal: dm_rdata shows the old word until the edge, then the new word.
- Reset mid-operation: rst=1 on an edge where rf_we or dm_we is also 1 leaves the target zero; the write is lost.
- No X propagation: all storage is defined after the first reset edge.
- No handshakes; every operation is single-cycle.

Test Plan:
- Reset: assert rst for 1 edge with pc_in=7, rf_we=1, rf_aw=3, rf_dw=0xFFFF_FFFF -> pc_out=0, rf_dr1(ar1=3)=0, dm_rdata(re=1, addr=3)=0.
- PC sequencing: rst=0, pc_in=1,2,...,31,0 on consecutive edges -> pc_out follows pc_in one edge later, including the 31 -> 0 wrap.
- Register write/read: write 0x1234_5678 to r5 and 0xDEAD_BEEF to r6 -> ar1=5, ar2=6 gives 0x1234_5678 / 0xDEAD_BEEF combinationally. Write 0xAAAA_AAAA to r0 -> reads of r0 stay 0.
- Register collision: rf_we=1, rf_aw=ar1=9, old r9=0x11, rf_dw=0x22 -> rf_dr1=0x11 before the edge, 0x22 after.
- Memory write/read: dm_we=1, addr=4, wdata=0xCAFE_0001; next cycle dm_re=1, addr=4 -> dm_rdata=0xCAFE_0001. Same read with dm_re=0 -> 0. addr=0x24 aliases index 4 -> 0xCAFE_0001.
- Reset priority: rst=1 together with dm_we=1, addr=2, wdata=5 -> mem[2] reads 0 afterward.

Source files
------------

// File: rtl/cpu_state_units.sv
// cpu_state_units: architectural state of the single-cycle datapath.
// Holds the program counter, a 2-read/1-write register file with r0 tied
// to zero, and a word-indexed data memory. Every update happens on the
// rising edge of clk, and a synchronous reset clears all storage.
// Reads are combinational and have no write-to-read bypass. A read of an
// address being written in the same cycle returns the old value until the edge.
module cpu_state_units #(
  parameter int PC_W   = 5,
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5,
  parameter int DM_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc_in,
  output logic [PC_W-1:0]   pc_out,
  input  logic [RF_AW-1:0]  rf_ar1,
  input  logic [RF_AW-1:0]  rf_ar2,
  input  logic [RF_AW-1:0]  rf_aw,
  input  logic [DATA_W-1:0] rf_dw,
  input  logic              rf_we,
  output logic [DATA_W-1:0] rf_dr1,
  output logic [DATA_W-1:0] rf_dr2,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_we,
  input  logic              dm_re,
  output logic [DATA_W-1:0] dm_rdata
);

  localparam int RF_DEPTH = 2 ** RF_AW;
  localparam int DM_DEPTH = 2 ** DM_AW;

  logic [DATA_W-1:0] regs [RF_DEPTH];
  logic [DATA_W-1:0] mem  [DM_DEPTH];
  logic [DM_AW-1:0]  dm_idx;
  logic              unused_dm_addr_hi;

  // Upper address bits alias onto the same words. They are intentionally ignored.
  assign dm_idx            = dm_addr[DM_AW-1:0];
  assign unused_dm_addr_hi = ^dm_addr[DATA_W-1:DM_AW];

  // Program counter: loads pc_in unconditionally every cycle. The driver handles wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out <= '0;
    end else begin
      pc_out <= pc_in;
    end
  end

  // Register file write port. Writes to r0 are dropped, so r0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (rf_we && (rf_aw != '0)) begin
      regs[rf_aw] <= rf_dw;
    end
  end

  // Data memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (dm_we) begin
      mem[dm_idx] <= dm_wdata;
    end
  end

  // Combinational read ports. r0 is forced to zero independently of storage.
  always_comb begin
    rf_dr1   = '0;
    rf_dr2   = '0;
    dm_rdata = '0;
    if (rf_ar1 != '0) rf_dr1 = regs[rf_ar1];
    if (rf_ar2 != '0) rf_dr2 = regs[rf_ar2];
    if (dm_re)        dm_rdata = mem[dm_idx];
  end

endmodule

// File: tb/tb_cpu_state_units.sv
// tb_cpu_state_units: directed vectors with hand-computed expectations for
// the PC, register file and data memory of cpu_state_units.
module tb_cpu_state_units;

  logic        clk;
  logic        rst;
  logic [4:0]  pc_in;
  logic [4:0]  pc_out;
  logic [4:0]  rf_ar1;
  logic [4:0]  rf_ar2;
  logic [4:0]  rf_aw;
  logic [31:0] rf_dw;
  logic        rf_we;
  logic [31:0] rf_dr1;
  logic [31:0] rf_dr2;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic        dm_re;
  logic [31:0] dm_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_state_units dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pc_in),
    .pc_out   (pc_out),
    .rf_ar1   (rf_ar1),
    .rf_ar2   (rf_ar2),
    .rf_aw    (rf_aw),
    .rf_dw    (rf_dw),
    .rf_we    (rf_we),
    .rf_dr1   (rf_dr1),
    .rf_dr2   (rf_dr2),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_re    (dm_re),
    .dm_rdata (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_in = 5'd7;
    rf_ar1 = '0; rf_ar2 = '0; rf_aw = 5'd3; rf_dw = 32'hFFFF_FFFF; rf_we = 1'b1;
    dm_addr = 32'd3; dm_wdata = 32'h1; dm_we = 1'b1; dm_re = 1'b0;
    #2;
    tick();

    // Reset state: the write that coincided with reset must be lost.
    rst = 1'b0; rf_we = 1'b0; dm_we = 1'b0;
    rf_ar1 = 5'd3; dm_re = 1'b1; dm_addr = 32'd3;
    #1;
    check_eq("reset_pc", 32'(pc_out), 32'd0);
    check_eq("reset_r3", rf_dr1, 32'd0);
    check_eq("reset_mem3", dm_rdata, 32'd0);

    // PC sequencing including 31 -> 0.
    for (int i = 1; i <= 32; i++) begin
      pc_in = 5'(i);
      #1;
      check_eq("pc_hold", 32'(pc_out), 32'(i - 1));
      tick();
      check_eq("pc_follow", 32'(pc_out), 32'(i % 32));
    end

    // Register writes, including the discarded r0 write.
    rf_we = 1'b1; rf_aw = 5'd5; rf_dw = 32'h1234_5678; tick();
    rf_aw = 5'd6; rf_dw = 32'hDEAD_BEEF; tick();
    rf_aw = 5'd0; rf_dw = 32'hAAAA_AAAA; tick();
    rf_we = 1'b0;
    rf_ar1 = 5'd5; rf_ar2 = 5'd6; #1;
    check_eq("rf_r5", rf_dr1, 32'h1234_5678);
    check_eq("rf_r6", rf_dr2, 32'hDEAD_BEEF);
    rf_ar1 = 5'd6; rf_ar2 = 5'd5; #1;
    check_eq("rf_async_r6", rf_dr1, 32'hDEAD_BEEF);
    check_eq("rf_async_r5", rf_dr2, 32'h1234_5678);
    rf_ar1 = 5'd0; rf_ar2 = 5'd0; #1;
    check_eq("rf_r0_p1", rf_dr1, 32'd0);
    check_eq("rf_r0_p2", rf_dr2, 32'd0);

    // Register collision: old value before the edge, new value after.
    rf_we = 1'b1; rf_aw = 5'd9; rf_dw = 32'h11; tick();
    rf_dw = 32'h22; rf_ar1 = 5'd9; #1;
    check_eq("rf_coll_old", rf_dr1, 32'h11);
    tick();
    rf_we = 1'b0; #1;
    check_eq("rf_coll_new", rf_dr1, 32'h22);

    // Memory write and read.
    dm_re = 1'b0; dm_we = 1'b1; dm_addr = 32'd4; dm_wdata = 32'hCAFE_0001; #1;
    check_eq("dm_re0_pre", dm_rdata, 32'd0);
    tick();
    dm_we = 1'b0; dm_re = 1'b1; #1;
    check_eq("dm_rd4", dm_rdata, 32'hCAFE_0001);
    dm_re = 1'b0; #1;
    check_eq("dm_re0", dm_rdata, 32'd0);
    dm_re = 1'b1; dm_addr = 32'h24; #1;
    check_eq("dm_alias", dm_rdata, 32'hCAFE_0001);
    dm_addr = 32'd5; #1;
    check_eq("dm_rd5_empty", dm_rdata, 32'd0);

    // Top index, reached through an aliased high address.
    dm_we = 1'b1; dm_addr = 32'hFFFF_FFFF; dm_wdata = 32'h0BAD_F00D; tick();
    dm_we = 1'b0; dm_addr = 32'd31; #1;
    check_eq("dm_rd31", dm_rdata, 32'h0BAD_F00D);

    // Simultaneous read and write of one word.
    dm_addr = 32'd4; dm_we = 1'b1; dm_wdata = 32'h55; #1;
    check_eq("dm_rw_old", dm_rdata, 32'hCAFE_0001);
    tick();
    dm_we = 1'b0; #1;
    check_eq("dm_rw_new", dm_rdata, 32'h55);

    // Reset priority over concurrent writes.
    rst = 1'b1; dm_we = 1'b1; dm_addr = 32'd2; dm_wdata = 32'd5;
    rf_we = 1'b1; rf_aw = 5'd7; rf_dw = 32'h99; pc_in = 5'd12;
    tick();
    rst = 1'b0; dm_we = 1'b0; rf_we = 1'b0; dm_re = 1'b1;
    rf_ar1 = 5'd7; rf_ar2 = 5'd5; #1;
    check_eq("rstp_mem2", dm_rdata, 32'd0);
    check_eq("rstp_r7", rf_dr1, 32'd0);
    check_eq("rstp_r5", rf_dr2, 32'd0);
    check_eq("rstp_pc", 32'(pc_out), 32'd0);
    dm_addr = 32'd4; #1;
    check_eq("rstp_mem4", dm_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
